// File: rtl/rx_packet_fifo_if.sv
// Bus bundle between the USB receiver / microcontroller side and rx_packet_fifo.
// master drives writes, commit/rollback, reads and clear_err; slave is the FIFO.
interface rx_packet_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  w_enable;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  commit;
    logic                  rollback;
    logic                  r_enable;
    logic                  clear_err;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;
    logic                  pkt_drop;

    modport master (
        output w_enable, w_data, commit, rollback, r_enable, clear_err,
        input  r_data, empty, full, almost_full, count, overflow, underflow, pkt_drop
    );

    modport slave (
        input  w_enable, w_data, commit, rollback, r_enable, clear_err,
        output r_data, empty, full, almost_full, count, overflow, underflow, pkt_drop
    );
endinterface

// File: rtl/rx_packet_fifo.sv
// Packet-aware receive FIFO: bytes are written speculatively and become readable
// only on commit; rollback or an overflowed packet discards the partial packet.
module rx_packet_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_THRESH  = DEPTH - 2
) (
    input  logic clk,
    input  logic rst,
    rx_packet_fifo_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         cm_ptr_q, cm_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  pkt_bad_q, pkt_bad_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  pkt_drop_q, pkt_drop_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] spec_fill;
    logic [PW-1:0] cm_fill;
    logic          full_w;
    logic          empty_w;
    logic          wr_en;
    logic          rd_en;
    logic          drop;

    // Status flags come from registered pointers only.
    assign spec_fill = wr_ptr_q - rd_ptr_q;
    assign cm_fill   = cm_ptr_q - rd_ptr_q;
    assign full_w    = (spec_fill == PW'(DEPTH));
    assign empty_w   = (cm_fill == '0);

    assign wr_en = bus.w_enable && !full_w;
    assign rd_en = bus.r_enable && !empty_w;
    assign drop  = bus.rollback || (bus.commit && pkt_bad_q);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        cm_ptr_d    = cm_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pkt_bad_d   = pkt_bad_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        pkt_drop_d  = drop;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // Commit captures the post-write pointer so a same-cycle byte is included.
        if (drop) begin
            wr_ptr_d = cm_ptr_q;
        end else if (bus.commit) begin
            cm_ptr_d = wr_ptr_d;
        end

        if (bus.commit || bus.rollback) begin
            pkt_bad_d = 1'b0;
        end else if (bus.w_enable && full_w) begin
            pkt_bad_d = 1'b1;
        end

        // Sticky error flags: a new error beats clear_err.
        if (bus.clear_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (bus.w_enable && full_w) begin
            overflow_d = 1'b1;
        end
        if (bus.r_enable && empty_w) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            cm_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_bad_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            pkt_drop_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            cm_ptr_q    <= cm_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_bad_q   <= pkt_bad_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            pkt_drop_q  <= pkt_drop_d;
        end
    end

    // Storage carries no reset; a discarded write never lands.
    always_ff @(posedge clk) begin
        if (wr_en && !drop && !rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.w_data;
        end
    end

    assign bus.r_data      = empty_w ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.empty       = empty_w;
    assign bus.full        = full_w;
    assign bus.almost_full = (spec_fill >= PW'(AF_THRESH));
    assign bus.count       = cm_fill;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
    assign bus.pkt_drop    = pkt_drop_q;
endmodule
